// File: rtl/ifft_sdf_sequencer.sv
// Master sequencer for the 64-point SDF IFFT pipeline: stage select lines,
// twiddle start pulses, pipeline enable, output framing and flush on input stop.
module ifft_sdf_sequencer #(
  parameter int NFFT      = 64,
  parameter int LOGN      = 6,
  parameter int STAGE_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            pipe_en,
  output logic [LOGN-1:0] bf_sel,
  output logic [LOGN-2:0] tw_active,
  output logic            out_valid,
  output logic            out_last,
  output logic            busy,
  output logic            err,
  output logic [1:0]      state_dbg
);

  // Handshake: a sample is taken on any cycle with in_valid & in_ready. In RUN a
  // low in_valid mid-frame is a bubble (slot still consumed, err set); a low
  // in_valid on the first slot of a frame ends input and starts the flush.

  // Cycle at which frame 0 reaches the input of stage k.
  function automatic int stage_arrival(input int k);
    int a;
    a = 0;
    for (int j = 0; j < k; j++) a += (NFFT >> (j + 1)) + STAGE_LAT;
    return a;
  endfunction

  localparam int L  = NFFT - 1 + LOGN * STAGE_LAT;
  localparam int GW = $clog2(L + 1);
  localparam logic [GW-1:0]   L_G        = GW'(L);
  localparam logic [GW-1:0]   FLUSH_LAST = GW'(L - 1);
  localparam logic [LOGN-1:0] CNT_LAST   = LOGN'(NFFT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

  state_t          state, state_n;
  logic [LOGN-1:0] phase;      // g mod NFFT; equals in_cnt while in RUN
  logic [GW-1:0]   g_sat;      // g, saturating at L (only used for priming)
  logic [GW-1:0]   flush_cnt;  // flush cycles elapsed; the RUN boundary cycle is 0
  logic [LOGN-1:0] out_cnt;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid) state_n = RUN;
      RUN:     if (phase == '0 && !in_valid) state_n = FLUSH;
      FLUSH:   if (flush_cnt == FLUSH_LAST) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      phase     <= '0;
      g_sat     <= '0;
      flush_cnt <= '0;
      out_cnt   <= '0;
      err       <= 1'b0;
    end else begin
      state <= state_n;
      if (state == RUN && phase != '0 && !in_valid) err <= 1'b1;
      if (state_n == IDLE) begin
        phase     <= '0;
        g_sat     <= '0;
        flush_cnt <= '0;
        out_cnt   <= '0;
      end else begin
        phase <= phase + 1'b1;
        if (g_sat != L_G) g_sat <= g_sat + 1'b1;
        flush_cnt <= (state_n == FLUSH) ? flush_cnt + 1'b1 : '0;
        if (out_valid) out_cnt <= out_cnt + 1'b1;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign pipe_en   = busy;
  assign in_ready  = (state != FLUSH);
  assign out_valid = busy && (g_sat == L_G);
  assign out_last  = out_valid && (out_cnt == CNT_LAST);
  assign state_dbg = state;

  for (genvar k = 0; k < LOGN; k++) begin : g_stage
    localparam int AK = stage_arrival(k);
    localparam logic [GW-1:0]   AK_G = GW'(AK);
    localparam logic [LOGN-1:0] AK_P = LOGN'(AK);
    localparam logic [LOGN-1:0] MASK = LOGN'(1) << (LOGN - 1 - k);
    logic primed;
    if (AK == 0) begin : g_first
      assign primed = busy;
    end else begin : g_later
      assign primed = busy && (g_sat >= AK_G);
    end
    assign bf_sel[k] = primed && |((phase - AK_P) & MASK);
  end

  // A pulse in FLUSH belongs to a real frame only while fewer than D flush
  // cycles have elapsed; later phase matches are for frames never accepted.
  for (genvar k = 0; k < LOGN - 1; k++) begin : g_tw
    localparam int D = stage_arrival(k + 1) - 1;
    localparam logic [GW-1:0]   D_G = GW'(D);
    localparam logic [LOGN-1:0] D_P = LOGN'(D);
    assign tw_active[k] = busy && (phase == D_P) && (g_sat >= D_G) &&
                          (state != FLUSH || flush_cnt < D_G);
  end

endmodule

// File: tb/tb_ifft_sdf_sequencer.sv
// Directed bench for ifft_sdf_sequencer: per-cycle output capture, then checks
// against a hand-computed vector table and expected event-cycle queues.
module tb_ifft_sdf_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready, pipe_en, out_valid, out_last, busy, err;
  logic [5:0] bf_sel;
  logic [4:0] tw_active;
  logic [1:0] state_dbg;

  ifft_sdf_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .pipe_en(pipe_en), .bf_sel(bf_sel), .tw_active(tw_active),
    .out_valid(out_valid), .out_last(out_last), .busy(busy), .err(err),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  localparam int MAXC = 400;
  logic       stim_v [MAXC];
  logic       r_rdy [MAXC], r_pe [MAXC], r_busy [MAXC], r_ov [MAXC], r_ol [MAXC], r_err [MAXC];
  logic [5:0] r_bf [MAXC];
  logic [4:0] r_tw [MAXC];

  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];

  typedef struct {
    int         cyc;
    logic       rdy, bsy, pe, ov, ol;
    logic [5:0] bf;
    logic [4:0] tw;
  } vec_t;
  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_stim();
    for (int i = 0; i < MAXC; i++) stim_v[i] = 1'b0;
  endtask

  task automatic set_stim(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) stim_v[i] = 1'b1;
  endtask

  // Entered just after a rising edge with the DUT idle; cycle 0 is the first cycle.
  task automatic run_cycles(input int nc);
    for (int c = 0; c < nc; c++) begin
      in_valid = stim_v[c];
      @(negedge clk);
      r_rdy[c] = in_ready; r_pe[c] = pipe_en; r_busy[c] = busy;
      r_ov[c] = out_valid; r_ol[c] = out_last; r_err[c] = err;
      r_bf[c] = bf_sel; r_tw[c] = tw_active;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  // sel 0: tw_active[b] pulse cycles; sel 1: out_last cycles
  task automatic collect(input int sel, input int b, input int nc);
    got_q.delete();
    for (int c = 0; c < nc; c++)
      if ((sel == 0 && r_tw[c][b]) || (sel == 1 && r_ol[c])) got_q.push_back(16'(c));
  endtask

  task automatic compare_q(input string name);
    int n;
    check({name, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({name, "_cycle"}, got_q[i], exp_q[i]);
  endtask

  // Returns count of out_valid cycles, plus first and last valid cycle (-1 if none).
  task automatic ov_span(input int nc, output int cnt, output int first, output int last);
    cnt = 0; first = -1; last = -1;
    for (int c = 0; c < nc; c++)
      if (r_ov[c]) begin
        if (first < 0) first = c;
        last = c;
        cnt++;
      end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_pipe_en"}, pipe_en, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_bf_sel"}, bf_sel, 0);
    check({tag, "_tw_active"}, tw_active, 0);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, first, last, pe_cnt;

    // Reset held with in_valid toggling
    rst = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = ~in_valid;
      @(negedge clk);
      check_reset_outputs("reset_hold");
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;

    // Single frame: table of full output vectors at selected cycles
    vq.push_back('{0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, 5'b00000});
    vq.push_back('{1,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'b000000, 5'b00000});
    vq.push_back('{31,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'b000000, 5'b00000});
    vq.push_back('{32,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'b000001, 5'b00001});
    vq.push_back('{33,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'b000001, 5'b00000});
    vq.push_back('{49,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'b000011, 5'b00010});
    vq.push_back('{58,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'b000111, 5'b00100});
    vq.push_back('{63,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'b001111, 5'b01000});
    vq.push_back('{64,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'b001110, 5'b00000});
    vq.push_back('{66,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'b011000, 5'b10000});
    vq.push_back('{68,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'b100000, 5'b00000});
    vq.push_back('{69,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'b000000, 5'b00000});
    vq.push_back('{96,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'b101111, 5'b00000});
    vq.push_back('{100, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'b100001, 5'b00000});
    vq.push_back('{130, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'b111000, 5'b00000});
    vq.push_back('{132, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 6'b100000, 5'b00000});
    vq.push_back('{133, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, 5'b00000});

    clear_stim();
    set_stim(0, 63);
    run_cycles(140);
    for (int i = 0; i < vq.size(); i++) begin
      int c;
      c = vq[i].cyc;
      check($sformatf("single_c%0d_in_ready", c), r_rdy[c], vq[i].rdy);
      check($sformatf("single_c%0d_busy", c), r_busy[c], vq[i].bsy);
      check($sformatf("single_c%0d_pipe_en", c), r_pe[c], vq[i].pe);
      check($sformatf("single_c%0d_out_valid", c), r_ov[c], vq[i].ov);
      check($sformatf("single_c%0d_out_last", c), r_ol[c], vq[i].ol);
      check($sformatf("single_c%0d_bf_sel", c), r_bf[c], vq[i].bf);
      check($sformatf("single_c%0d_tw_active", c), r_tw[c], vq[i].tw);
    end
    ov_span(140, cnt, first, last);
    check("single_ov_count", cnt, 64);
    check("single_ov_first", first, 69);
    check("single_ov_last", last, 132);

    // Three back-to-back frames
    clear_stim();
    set_stim(0, 191);
    run_cycles(270);
    ov_span(270, cnt, first, last);
    check("three_ov_count", cnt, 192);
    check("three_ov_first", first, 69);
    check("three_ov_last", last, 260);
    collect(0, 0, 270);
    exp_q = '{16'd32, 16'd96, 16'd160};
    compare_q("three_tw0");
    collect(0, 4, 270);
    exp_q = '{16'd66, 16'd130, 16'd194};
    compare_q("three_tw4");
    collect(1, 0, 270);
    exp_q = '{16'd132, 16'd196, 16'd260};
    compare_q("three_out_last");
    check("three_busy_260", r_busy[260], 1);
    check("three_busy_261", r_busy[261], 0);

    // Bubble at cycle 10
    clear_stim();
    set_stim(0, 63);
    stim_v[10] = 1'b0;
    run_cycles(140);
    check("bubble_err_10", r_err[10], 0);
    check("bubble_err_11", r_err[11], 1);
    check("bubble_err_139", r_err[139], 1);
    pe_cnt = 0;
    for (int c = 1; c <= 132; c++) if (r_pe[c]) pe_cnt++;
    check("bubble_pipe_en_count", pe_cnt, 132);
    ov_span(140, cnt, first, last);
    check("bubble_ov_count", cnt, 64);
    check("bubble_ov_first", first, 69);
    check("bubble_ov_last", last, 132);

    // Reset mid-flush at cycle 100, then a fresh frame
    clear_stim();
    set_stim(0, 63);
    run_cycles(100);
    rst = 1'b0;
    in_valid = 1'b1;
    #2;
    check_reset_outputs("midflush_reset");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_reset_outputs("midflush_held");
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    clear_stim();
    set_stim(0, 63);
    run_cycles(140);
    ov_span(140, cnt, first, last);
    check("after_reset_ov_count", cnt, 64);
    check("after_reset_ov_first", first, 69);
    collect(1, 0, 140);
    exp_q = '{16'd132};
    compare_q("after_reset_out_last");

    // in_valid held high during FLUSH; frame re-accepted on return to IDLE
    clear_stim();
    set_stim(0, 63);
    set_stim(80, 196);
    run_cycles(280);
    check("flushin_rdy_80", r_rdy[80], 0);
    check("flushin_busy_133", r_busy[133], 0);
    check("flushin_rdy_133", r_rdy[133], 1);
    check("flushin_busy_134", r_busy[134], 1);
    check("flushin_ov_201", r_ov[201], 0);
    check("flushin_ov_202", r_ov[202], 1);
    check("flushin_err_279", r_err[279], 0);
    ov_span(280, cnt, first, last);
    check("flushin_ov_count", cnt, 128);
    collect(1, 0, 280);
    exp_q = '{16'd132, 16'd265};
    compare_q("flushin_out_last");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
